// File: rtl/fm_demod_pkg.sv
// rtl/fm_demod_pkg.sv - shared types, angle constants and fixed-point helpers for fm_demod_mc
package fm_demod_pkg;

  typedef enum logic [2:0] {
    S_READ,
    S_MULT,
    S_SETUP,
    S_DIVIDE,
    S_ANGLE,
    S_DEEMPH,
    S_WRITE
  } state_t;

  // pi/4 and 3*pi/4 in Q10; rescaled by the top for other fraction widths
  localparam int QUAD1_Q10 = 804;
  localparam int QUAD3_Q10 = 2412;

  function automatic logic signed [63:0] mul_frac(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int frac);
    logic signed [63:0] p;
    p = a * b;
    return p >>> frac;
  endfunction

  function automatic logic signed [63:0] sat_mag(input logic [63:0] mag,
                                                 input logic neg,
                                                 input int w);
    logic [63:0] lim;
    logic [63:0] m;
    lim = (64'd1 << (w - 1)) - 64'd1;
    m   = (mag > lim) ? lim : mag;
    return neg ? -$signed(m) : $signed(m);
  endfunction

endpackage

// File: rtl/div_seq_signed.sv
// rtl/div_seq_signed.sv - restoring signed divider, done pulses W+1 cycles after start
module div_seq_signed
  import fm_demod_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [W-1:0] dividend,
  input  logic signed [W-1:0] divisor,
  output logic                done,
  output logic signed [W-1:0] quotient
);

  localparam int CNT_W = $clog2(W + 1);

  logic [W-1:0]     quo;
  logic [W-1:0]     dvs;
  logic [W:0]       rem;
  logic [W:0]       rem_sh;
  logic [W:0]       diff;
  logic             neg;
  logic             busy;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    rem_sh = {rem[W-1:0], quo[W-1]};
    diff   = rem_sh - {1'b0, dvs};
  end

  // Magnitudes are divided unsigned; the sign is re-applied with saturation
  assign quotient = W'(sat_mag(64'(quo), neg, W));

  always_ff @(posedge clk) begin
    if (rst) begin
      quo  <= '0;
      dvs  <= '0;
      rem  <= '0;
      neg  <= 1'b0;
      busy <= 1'b0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quo  <= dividend[W-1] ? W'(-dividend) : W'(dividend);
        dvs  <= divisor[W-1] ? W'(-divisor) : W'(divisor);
        rem  <= '0;
        neg  <= dividend[W-1] ^ divisor[W-1];
        cnt  <= CNT_W'(W);
        busy <= 1'b1;
      end else if (busy) begin
        quo <= {quo[W-2:0], ~diff[W]};
        rem <= diff[W] ? rem_sh : diff;
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fm_demod_mc.sv
// rtl/fm_demod_mc.sv - N-channel time-multiplexed FM quadrature discriminator
// Optional de-emphasis stage: FM_DEMOD_DEEMPH_EN
module fm_demod_mc
  import fm_demod_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int FRAC_BITS    = 10,
  parameter int NUM_CH       = 2,
  parameter int GAIN         = 758,
  parameter int DEEMPH_ALPHA = 174
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic signed [DATA_WIDTH-1:0]                  in_rl,
  input  logic signed [DATA_WIDTH-1:0]                  in_img,
  input  logic                                          in_empty,
  output logic                                          in_rd_en,
  output logic signed [DATA_WIDTH-1:0]                  out_data,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch,
  input  logic                                          out_full,
  output logic                                          out_wr_en
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DW   = DATA_WIDTH;
  localparam logic signed [DW-1:0] Q1     = DW'((QUAD1_Q10 * (1 << FRAC_BITS)) / 1024);
  localparam logic signed [DW-1:0] Q3     = DW'((QUAD3_Q10 * (1 << FRAC_BITS)) / 1024);
  localparam logic signed [DW-1:0] GAIN_S = DW'(GAIN);
  localparam logic [CH_W-1:0]      LAST_CH = CH_W'(NUM_CH - 1);

  if (DEEMPH_ALPHA > (1 << FRAC_BITS)) begin : g_alpha_above_unity
  end

  function automatic logic signed [DW-1:0] mf(input logic signed [DW-1:0] a,
                                              input logic signed [DW-1:0] b);
    return DW'(mul_frac(64'(a), 64'(b), FRAC_BITS));
  endfunction

  state_t                state, state_nx;
  logic [CH_W-1:0]       ptr, ch_q;
  logic signed [DW-1:0]  cur_rl, cur_img, r_q, i_q, y_q;
  logic signed [DW-1:0]  div_dd, div_dv, div_quo;
  logic                  div_start, div_done;
  logic signed [DW-1:0]  prev_rl [NUM_CH];
  logic signed [DW-1:0]  prev_img[NUM_CH];
  logic signed [DW-1:0]  abs_i, ia, t, a, gain_y;
`ifdef FM_DEMOD_DEEMPH_EN
  logic signed [DW-1:0]  a_q, y_de;
  logic signed [DW-1:0]  d_st[NUM_CH];
  localparam logic signed [DW-1:0] ALPHA_S = DW'(DEEMPH_ALPHA);
`endif

  div_seq_signed #(.W(DW)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dd),
    .divisor  (div_dv),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_comb begin
    abs_i  = i_q[DW-1] ? -i_q : i_q;
    ia     = abs_i + DW'(1);
    t      = mf(Q1, div_quo);
    a      = (r_q[DW-1] ? Q3 : Q1) - t;
    if (i_q[DW-1]) a = -a;
    gain_y = mf(GAIN_S, y_q);
`ifdef FM_DEMOD_DEEMPH_EN
    y_de   = d_st[ch_q] + mf(a_q - d_st[ch_q], ALPHA_S);
`endif
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_READ:   if (!in_empty) state_nx = S_MULT;
      S_MULT:   state_nx = S_SETUP;
      S_SETUP:  state_nx = S_DIVIDE;
      S_DIVIDE: if (div_done) state_nx = S_ANGLE;
`ifdef FM_DEMOD_DEEMPH_EN
      S_ANGLE:  state_nx = S_DEEMPH;
      S_DEEMPH: state_nx = S_WRITE;
`else
      S_ANGLE:  state_nx = S_WRITE;
`endif
      S_WRITE:  if (!out_full) state_nx = S_READ;
      default:  state_nx = S_READ;
    endcase
  end

  // Outputs show the pending result only in the cycle it is pushed
  logic signed [DW-1:0] out_data_q;
  logic [CH_W-1:0]      out_ch_q;
  assign in_rd_en  = !rst && (state == S_READ) && !in_empty;
  assign out_wr_en = !rst && (state == S_WRITE) && !out_full;
  assign out_data  = out_wr_en ? gain_y : out_data_q;
  assign out_ch    = out_wr_en ? ch_q : out_ch_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_READ;
      ptr        <= '0;
      ch_q       <= '0;
      cur_rl     <= '0;
      cur_img    <= '0;
      r_q        <= '0;
      i_q        <= '0;
      y_q        <= '0;
      div_dd     <= '0;
      div_dv     <= '0;
      div_start  <= 1'b0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        prev_rl[k]  <= '0;
        prev_img[k] <= '0;
`ifdef FM_DEMOD_DEEMPH_EN
        d_st[k]     <= '0;
`endif
      end
`ifdef FM_DEMOD_DEEMPH_EN
      a_q        <= '0;
`endif
    end else begin
      state     <= state_nx;
      div_start <= 1'b0;
      case (state)
        S_READ: if (!in_empty) begin
          cur_rl  <= in_rl;
          cur_img <= in_img;
          ch_q    <= ptr;
        end
        S_MULT: begin
          r_q <= mf(prev_rl[ch_q], cur_rl) + mf(prev_img[ch_q], cur_img);
          i_q <= mf(prev_rl[ch_q], cur_img) - mf(prev_img[ch_q], cur_rl);
          prev_rl[ch_q]  <= cur_rl;
          prev_img[ch_q] <= cur_img;
        end
        S_SETUP: begin
          div_dd    <= (r_q[DW-1] ? (r_q + ia) : (r_q - ia)) <<< FRAC_BITS;
          div_dv    <= r_q[DW-1] ? (ia - r_q) : (r_q + ia);
          div_start <= 1'b1;
        end
`ifdef FM_DEMOD_DEEMPH_EN
        S_ANGLE: a_q <= a;
        S_DEEMPH: begin
          y_q        <= y_de;
          d_st[ch_q] <= y_de;
        end
`else
        S_ANGLE: y_q <= a;
`endif
        S_WRITE: if (!out_full) begin
          out_data_q <= gain_y;
          out_ch_q   <= ch_q;
          ptr        <= (ptr == LAST_CH) ? '0 : ptr + CH_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fm_demod_mc.sv
// tb/tb_fm_demod_mc.sv - scoreboard bench for fm_demod_mc (default build, 2 channels)
module tb_fm_demod_mc;

  typedef struct { int rl; int img; } iq_t;
  typedef struct { int data; int ch; } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [31:0] in_rl = '0;
  logic signed [31:0] in_img = '0;
  logic               in_empty = 1'b1;
  logic               in_rd_en;
  logic signed [31:0] out_data;
  logic [0:0]         out_ch;
  logic               out_full = 1'b0;
  logic               out_wr_en;

  fm_demod_mc #(
    .DATA_WIDTH(32), .FRAC_BITS(10), .NUM_CH(2), .GAIN(758), .DEEMPH_ALPHA(174)
  ) dut (
    .clk(clk), .rst(rst), .in_rl(in_rl), .in_img(in_img), .in_empty(in_empty),
    .in_rd_en(in_rd_en), .out_data(out_data), .out_ch(out_ch),
    .out_full(out_full), .out_wr_en(out_wr_en)
  );

  always #5 clk = ~clk;

  iq_t  in_q[$];
  exp_t exp_q[$];
  int   rd_times[$];
  int   wr_times[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  logic pop_pending = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push(input int rl, input int img, input int ed, input int ec);
    iq_t  s;
    exp_t e;
    s.rl = rl; s.img = img;
    in_q.push_back(s);
    e.data = ed; e.ch = ec;
    exp_q.push_back(e);
  endtask

  task automatic push_noexp(input int rl, input int img);
    iq_t s;
    s.rl = rl; s.img = img;
    in_q.push_back(s);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || in_q.size() != 0) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k < 3000) n_pass++;
    else $display("FAIL %s: timeout with %0d outputs pending, required 0", name, exp_q.size());
    repeat (2) @(negedge clk);
  endtask

  // Input FIFO model: first-word-fall-through, pop on the edge after rd_en
  always @(posedge clk) begin
    iq_t tmp;
    cyc++;
    #1;
    if (pop_pending && in_q.size() > 0) tmp = in_q.pop_front();
    pop_pending = 1'b0;
    if (in_q.size() > 0) begin
      in_empty = 1'b0;
      in_rl    = in_q[0].rl;
      in_img   = in_q[0].img;
    end else begin
      in_empty = 1'b1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    pop_pending = in_rd_en;
    if (!rst && in_rd_en) begin
      rd_cnt++;
      rd_times.push_back(cyc);
    end
    if (!rst && out_wr_en) begin
      wr_cnt++;
      wr_times.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_ch", out_ch, e.ch);
      end
    end
  end

  initial begin
    int rd0, wr0;
    // Samples queued during reset must not be popped
    push(1024, 0, 1190, 0);
    repeat (3) @(negedge clk);
    check("rst_rd_en", in_rd_en, 0);
    check("rst_wr_en", out_wr_en, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    rst = 1'b0;

    push(1024, 0, 1190, 1);
    push(1024, 0, 1, 0);
    push(0, 1024, 1190, 1);
    push(0, 1024, 1190, 0);
    push(0, -1024, 2379, 1);
    push(1024, 0, -1191, 0);
    push(0, -1024, 1, 1);
    push(0, -1024, -1191, 0);
    push(-1024, 0, -1191, 1);
    push(2048, 0, 1190, 0);
    push(-1024, 0, 1, 1);
    wait_drain("interleaved");
    check("latency", wr_times[0] - rd_times[0], 38);
    check("throughput", rd_times[2] - rd_times[1], 39);

    // Reset while the divider is running discards the sample and history
    push_noexp(3000, -700);
    begin
      int k;
      k = 0;
      while (in_q.size() != 0 && k < 100) begin @(negedge clk); k++; end
    end
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push(1024, 0, 1190, 0);
    wait_drain("after_reset");

    // Back-pressure: result must wait in WRITE without popping more input
    out_full = 1'b1;
    push(1024, 0, 1190, 1);
    push(1024, 0, 1, 0);
    repeat (45) @(negedge clk);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    repeat (100) @(negedge clk);
    check("stall_rd", rd_cnt - rd0, 0);
    check("stall_wr", wr_cnt - wr0, 0);
    check("stall_hold", out_data, 1190);
    out_full = 1'b0;
    wait_drain("stall_release");
    check("stall_writes", wr_cnt - wr0, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
